// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the multiplexed BCD display path.
//   DEF_NUM_DIGITS : default digit count for the converter and scan driver
//   BCD_BLANK      : code the downstream 7-segment decoder renders as all-off
//   bcd_digit_t    : one BCD digit
//   conv_state_e   : binary-to-BCD conversion FSM states
//   pow10()        : elaboration-time power of ten for range checks
package display_pkg;

  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_BLANK      = 4'hF;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to BCD converter.
// One bit is processed per clock: BIN_WIDTH CONV cycles, then one COMMIT cycle.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bin_i      : binary value, captured when load_i is seen in IDLE
//   load_i     : start request, ignored while busy_o is high
//   busy_o     : FSM not in IDLE
//   valid_o    : high during the COMMIT cycle; bcd_o/ovf_o are final then
//   ovf_o      : captured value exceeded 10^NUM_DIGITS-1
//   bcd_o      : NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned BIN_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  input  logic                    load_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic                    ovf_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned         BCD_W    = 4 * NUM_DIGITS;
  localparam int unsigned         CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(BIN_WIDTH - 1);
  localparam int unsigned         MAX_VAL  = pow10(NUM_DIGITS) - 1;

  conv_state_e        r_state;
  logic [BCD_W-1:0]   r_bcd;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [BCD_W-1:0]   w_adj;

  // Add-3 correction on every nibble >= 5 ahead of the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_i) begin
            r_state <= CONV;
            r_bin   <= bin_i;
            r_bcd   <= '0;
            r_cnt   <= CNT_INIT;
            r_ovf   <= (32'(bin_i) > MAX_VAL);
          end
        end
        CONV: begin
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
          r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) r_state <= COMMIT;
        end
        COMMIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state != IDLE);
  assign valid_o = (r_state == COMMIT);
  assign ovf_o   = r_ovf;
  // Out-of-range input saturates to all nines regardless of shift result.
  assign bcd_o   = r_ovf ? {NUM_DIGITS{4'd9}} : r_bcd;

endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: converts a binary value to BCD digits and time-multiplexes
// them onto one 4-bit bus with active-low one-hot anode enables.
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading zero
// digits (except digit 0) are driven as BCD_BLANK on bcd_o.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bin_i      : binary value to display
//   load_i     : conversion request, sampled only while idle
//   busy_o     : conversion in progress
//   done_o     : one-cycle pulse on the first cycle new digits are shown
//   ovf_o      : last committed value was out of range (shown as all nines)
//   bcd_o      : BCD code of the digit currently enabled
//   an_o       : active-low one-hot digit enable, bit 0 = least significant
module bcd_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int unsigned BIN_WIDTH   = 14,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic [3:0]            bcd_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int unsigned    RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned    IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);

  logic                    w_valid;
  logic                    w_ovf;
  logic [4*NUM_DIGITS-1:0] w_bcd;

  bcd_digit_t [NUM_DIGITS-1:0] r_digits;
  logic                        r_done;
  logic                        r_ovf;
  logic [RW-1:0]               r_refresh;
  logic [IW-1:0]               r_idx;

  bcd_digit_t                  w_digit;
  logic [NUM_DIGITS-1:0]       w_an;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_WIDTH  (BIN_WIDTH)
  ) u_conv (
    .clk     (clk),
    .reset   (reset),
    .bin_i   (bin_i),
    .load_i  (load_i),
    .busy_o  (busy_o),
    .valid_o (w_valid),
    .ovf_o   (w_ovf),
    .bcd_o   (w_bcd)
  );

  // Committed digits only change on the COMMIT cycle, so the scan never
  // shows a partially converted value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_valid;
      if (w_valid) begin
        r_digits <= w_bcd;
        r_ovf    <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == REF_LAST) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  always_comb begin
    w_an        = '1;
    w_an[r_idx] = 1'b0;
    w_digit     = r_digits[r_idx];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // w_lz[i]: digit i and every digit above it are zero. Digit 0 never blanks.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      w_zero_run           = w_zero_run && (r_digits[NUM_DIGITS-k] == 4'd0);
      w_lz[NUM_DIGITS-k]   = w_zero_run;
    end
  end

  assign bcd_o = w_lz[r_idx] ? BCD_BLANK : w_digit;
`else
  assign bcd_o = w_digit;
`endif

  assign an_o   = w_an;
  assign done_o = r_done;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_bcd_scan_driver.sv
module tb_bcd_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned BW = 14;
  localparam int unsigned RD = 4;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic [BW-1:0] bin_i  = '0;
  logic          load_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;
  logic [3:0]    bcd_o;
  logic [ND-1:0] an_o;

  bcd_scan_driver #(
    .NUM_DIGITS  (ND),
    .BIN_WIDTH   (BW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bin_i  (bin_i),
    .load_i (load_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .ovf_o  (ovf_o),
    .bcd_o  (bcd_o),
    .an_o   (an_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_done   = 0;

  // Transaction-level reference: a pending request matures BW+1 edges after
  // acceptance; the display index is simply edges-since-reset / RD.
  int unsigned m_val      = 0;
  int unsigned m_pend_val = 0;
  int unsigned m_age      = 0;
  int unsigned m_scan     = 0;
  bit          m_ovf      = 1'b0;
  bit          m_done     = 1'b0;
  bit          m_pend     = 1'b0;

  typedef struct {
    int unsigned bin;
    logic [15:0] digits;   // zero-padded digits, digit 3 in the top nibble
    bit          ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_disp(input int unsigned val, input int unsigned idx);
    int unsigned p;
    int unsigned d;
    p = 1;
    for (int unsigned k = 0; k < idx; k++) p = p * 10;
    d = (val / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && val < p) d = 15;
`endif
    return d;
  endfunction

  function automatic logic [15:0] disp_from_digits(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      bit zr;
      zr = 1'b1;
      for (int k = 3; k >= 1; k--) begin
        zr = zr && (d[4*k +: 4] == 4'd0);
        if (zr) r[4*k +: 4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic tick();
    bit was_idle;
    int unsigned idx;
    @(posedge clk);
    if (reset) begin
      m_val = 0; m_ovf = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_scan = 0; m_age = 0;
    end else begin
      was_idle = !m_pend;
      m_done   = 1'b0;
      if (m_pend) begin
        m_age++;
        if (m_age == BW + 1) begin
          m_pend = 1'b0;
          m_done = 1'b1;
          if (m_pend_val > 9999) begin m_val = 9999; m_ovf = 1'b1; end
          else begin m_val = m_pend_val; m_ovf = 1'b0; end
        end
      end
      if (was_idle && load_i) begin
        m_pend = 1'b1; m_age = 0; m_pend_val = int'(bin_i);
      end
      m_scan++;
    end
    #1;
    idx = (m_scan / RD) % ND;
    chk("busy", 32'(busy_o), 32'(m_pend));
    chk("done", 32'(done_o), 32'(m_done));
    chk("ovf",  32'(ovf_o),  32'(m_ovf));
    chk("an",   32'(an_o),   (~(32'd1 << idx)) & 32'hF);
    chk("bcd",  32'(bcd_o),  exp_disp(m_val, idx));
    if (done_o === 1'b1) n_done++;
  endtask

  task automatic scan_digits(output logic [15:0] seen);
    seen = 16'hEEEE;
    for (int unsigned t = 0; t < 16; t++) begin
      tick();
      for (int unsigned i = 0; i < ND; i++)
        if (an_o[i] === 1'b0) seen[4*i +: 4] = bcd_o;
    end
  endtask

  initial begin
    logic [15:0] seen;
    int unsigned blen;

    vecs[0] = '{1234,  16'h1234, 1'b0};
    vecs[1] = '{10000, 16'h9999, 1'b1};
    vecs[2] = '{5,     16'h0005, 1'b0};
    vecs[3] = '{42,    16'h0042, 1'b0};
    vecs[4] = '{0,     16'h0000, 1'b0};
    vecs[5] = '{1002,  16'h1002, 1'b0};
    vecs[6] = '{9999,  16'h9999, 1'b0};
    vecs[7] = '{16383, 16'h9999, 1'b1};
    vecs[8] = '{1000,  16'h1000, 1'b0};
    vecs[9] = '{907,   16'h0907, 1'b0};

    // Reset state and idle scan rotation
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovf",  32'(ovf_o),  32'd0);
    chk("rst_an",   32'(an_o),   32'hE);
    chk("rst_bcd",  32'(bcd_o),  32'd0);
    reset = 1'b0;
    for (int unsigned n = 1; n <= 16; n++) begin
      tick();
      chk("idle_an",  32'(an_o),  (~(32'd1 << ((n / 4) % 4))) & 32'hF);
      chk("idle_bcd", 32'(bcd_o), 32'd0);
    end

    // Table: load, measure busy length, confirm done, read back scanned digits
    for (int unsigned v = 0; v < 10; v++) begin
      bin_i  = BW'(vecs[v].bin);
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
      blen = 1;
      while (busy_o === 1'b1 && blen < 40) begin
        tick();
        if (busy_o === 1'b1) blen++;
      end
      chk("busy_len", blen, 32'd15);
      chk("done_at_end", 32'(done_o), 32'd1);
      scan_digits(seen);
      chk("tbl_digits", 32'(seen), 32'(disp_from_digits(vecs[v].digits)));
      chk("tbl_ovf", 32'(ovf_o), 32'(vecs[v].ovf));
    end

    // Load while busy is dropped
    n_done = 0;
    bin_i = BW'(42); load_i = 1'b1; tick();
    load_i = 1'b0; tick(); tick();
    bin_i = BW'(7); load_i = 1'b1; tick();
    load_i = 1'b0;
    for (int unsigned t = 0; t < 25; t++) tick();
    chk("drop_done_cnt", n_done, 32'd1);
    scan_digits(seen);
    chk("drop_digits", 32'(seen), 32'(disp_from_digits(16'h0042)));

    // Reset during conversion aborts without done
    n_done = 0;
    bin_i = BW'(9999); load_i = 1'b1; tick();
    load_i = 1'b0;
    for (int unsigned t = 0; t < 5; t++) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_an",   32'(an_o),   32'hE);
    chk("abort_bcd",  32'(bcd_o),  32'd0);
    for (int unsigned t = 0; t < 20; t++) tick();
    chk("abort_done_cnt", n_done, 32'd0);
    scan_digits(seen);
    chk("abort_digits", 32'(seen), 32'(disp_from_digits(16'h0000)));

    // Held load re-triggers on each return to idle
    n_done = 0;
    bin_i = BW'(77); load_i = 1'b1;
    for (int unsigned t = 0; t < 40; t++) tick();
    load_i = 1'b0;
    chk("held_done_cnt", n_done, 32'd2);
    for (int unsigned t = 0; t < 20; t++) tick();

    // Randomized traffic against the reference
    for (int unsigned t = 0; t < 600; t++) begin
      reset  = ($urandom_range(0, 149) == 0);
      load_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) bin_i = BW'($urandom_range(10000, 16383));
      else                           bin_i = BW'($urandom_range(0, 9999));
      tick();
    end
    reset = 1'b0; load_i = 1'b0;
    for (int unsigned t = 0; t < 20; t++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
